// File: rtl/arkhe_noise_engine.sv
// Seeded xoshiro256-style random word engine with coherence-gated seed acceptance.
// Serves RESEED_INTERVAL words per seed through a valid/ready port, then asks to be reseeded.
module arkhe_noise_engine #(
    parameter logic [15:0] PHI_MIN         = 16'hD999,
    parameter int unsigned RESEED_INTERVAL = 4096
) (
    input  logic         clk_100mhz,
    input  logic         rst,
    input  logic [255:0] entropy_seed,
    input  logic         seed_valid,
    input  logic [63:0]  phi_acoustic,
    output logic [63:0]  rand_out,
    output logic         rand_valid,
    input  logic         rand_ready,
    output logic         reseed_req,
    output logic [15:0]  words_served,
    output logic [15:0]  seeds_rejected
);

    localparam logic [1:0] ST_UNSEEDED = 2'd0;
    localparam logic [1:0] ST_SEEDING  = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_STALE    = 2'd3;

    localparam logic [15:0] INTERVAL = 16'(RESEED_INTERVAL);

    logic [1:0]   state_q, state_d;
    logic [255:0] s_q, s_d;
    logic [63:0]  out_q, out_d;
    logic         valid_q, valid_d;
    logic [15:0]  ws_q, ws_d;
    logic [15:0]  rej_q, rej_d;

    logic [15:0]  ws_inc;
    logic [255:0] mix;
    logic         offer;
    logic         accept;
    logic         phi_unused;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] f_out(input logic [255:0] s);
        logic [63:0] m;
        m = s[127:64] * 64'd5;
        return rotl64(m, 7) * 64'd9;
    endfunction

    // Order of the xor updates matters: each step sees the already-updated words.
    function automatic logic [255:0] f_next(input logic [255:0] s);
        logic [63:0] w0, w1, w2, w3, t;
        w0 = s[63:0];
        w1 = s[127:64];
        w2 = s[191:128];
        w3 = s[255:192];
        t  = w1 << 17;
        w2 = w2 ^ w0;
        w3 = w3 ^ w1;
        w1 = w1 ^ w2;
        w0 = w0 ^ w3;
        w2 = w2 ^ t;
        w3 = rotl64(w3, 45);
        return {w3, w2, w1, w0};
    endfunction

    assign phi_unused = ^{phi_acoustic[63:48], phi_acoustic[31:0]};

    assign ws_inc = ws_q + 16'd1;
    assign mix    = s_q ^ entropy_seed;
    assign offer  = seed_valid && (state_q == ST_UNSEEDED || state_q == ST_STALE);
    assign accept = offer && (phi_acoustic[47:32] > PHI_MIN) && (|entropy_seed);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        out_d   = out_q;
        valid_d = valid_q;
        ws_d    = ws_q;
        rej_d   = rej_q;
        unique case (state_q)
            ST_UNSEEDED, ST_STALE: begin
                if (accept) begin
                    // A reseed that would cancel the state to zero falls back to the raw seed.
                    if (state_q == ST_UNSEEDED || mix == '0) begin
                        s_d = entropy_seed;
                    end else begin
                        s_d = mix;
                    end
                    ws_d    = '0;
                    state_d = ST_SEEDING;
                end else if (offer && rej_q != 16'hFFFF) begin
                    rej_d = rej_q + 16'd1;
                end
            end
            ST_SEEDING: begin
                out_d   = f_out(s_q);
                s_d     = f_next(s_q);
                valid_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (valid_q && rand_ready) begin
                    ws_d = ws_inc;
                    if (ws_inc == INTERVAL) begin
                        valid_d = 1'b0;
                        state_d = ST_STALE;
                    end else begin
                        out_d = f_out(s_q);
                        s_d   = f_next(s_q);
                    end
                end
            end
            default: state_d = ST_UNSEEDED;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNSEEDED;
            s_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ws_q    <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ws_q    <= ws_d;
            rej_q   <= rej_d;
        end
    end

    assign rand_out       = out_q;
    assign rand_valid     = valid_q;
    assign reseed_req     = (state_q == ST_UNSEEDED) || (state_q == ST_STALE);
    assign words_served   = ws_q;
    assign seeds_rejected = rej_q;

endmodule

// File: tb/tb_arkhe_noise_engine.sv
// Self-checking bench for arkhe_noise_engine: directed scenarios plus
// randomized traffic against a per-seed word-list reference model.
module tb_arkhe_noise_engine;

    localparam int          INT = 4;
    localparam logic [15:0] PHI = 16'hD999;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] entropy_seed = '0;
    logic         seed_valid = 1'b0;
    logic [63:0]  phi_acoustic = '0;
    logic [63:0]  rand_out;
    logic         rand_valid;
    logic         rand_ready = 1'b0;
    logic         reseed_req;
    logic [15:0]  words_served;
    logic [15:0]  seeds_rejected;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference model: on each accept, the full list of words for that seed
    bit           m_need, m_seeded, m_warm, m_valid;
    int           m_ws, m_rej, m_idx;
    logic [255:0] m_state;
    logic [63:0]  m_words[$];

    arkhe_noise_engine #(
        .PHI_MIN(PHI),
        .RESEED_INTERVAL(INT)
    ) dut (
        .clk_100mhz(clk),
        .rst(rst),
        .entropy_seed(entropy_seed),
        .seed_valid(seed_valid),
        .phi_acoustic(phi_acoustic),
        .rand_out(rand_out),
        .rand_valid(rand_valid),
        .rand_ready(rand_ready),
        .reseed_req(reseed_req),
        .words_served(words_served),
        .seeds_rejected(seeds_rejected)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] ref_word(input logic [255:0] s);
        return rotl(s[127:64] * 64'd5, 7) * 64'd9;
    endfunction

    function automatic logic [255:0] ref_next(input logic [255:0] s);
        logic [63:0] w[4];
        logic [63:0] t;
        for (int i = 0; i < 4; i++) w[i] = s[64*i +: 64];
        t = w[1] << 17;
        w[2] ^= w[0];
        w[3] ^= w[1];
        w[1] ^= w[2];
        w[0] ^= w[3];
        w[2] ^= t;
        w[3] = rotl(w[3], 45);
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [255:0] rnd_seed();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] mk_phi(input logic [15:0] p);
        logic [63:0] v;
        v = {$urandom, $urandom};
        v[47:32] = p;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_need = 1; m_seeded = 0; m_warm = 0; m_valid = 0;
        m_ws = 0; m_rej = 0; m_idx = 0;
        m_state = '0;
        m_words.delete();
    endtask

    task automatic predict(input bit sv, input logic [255:0] sd,
                           input logic [63:0] ph, input bit rdy);
        logic [255:0] s;
        if (m_need && sv) begin
            if (ph[47:32] > PHI && sd != '0) begin
                if (!m_seeded || (m_state ^ sd) == '0) s = sd;
                else s = m_state ^ sd;
                m_words.delete();
                for (int k = 0; k < INT; k++) begin
                    m_words.push_back(ref_word(s));
                    s = ref_next(s);
                end
                m_state = s;
                m_seeded = 1; m_need = 0; m_warm = 1; m_ws = 0;
            end else if (m_rej < 65535) begin
                m_rej++;
            end
        end else if (m_warm) begin
            m_warm = 0; m_valid = 1; m_idx = 0;
        end else if (m_valid && rdy) begin
            m_ws++;
            if (m_ws == INT) begin
                m_valid = 0; m_need = 1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, 64'(rand_valid), 64'(m_valid));
        chk({tag, ".reseed"}, 64'(reseed_req), 64'(m_need));
        chk({tag, ".served"}, 64'(words_served), 64'(m_ws));
        chk({tag, ".rejected"}, 64'(seeds_rejected), 64'(m_rej));
        if (m_valid) chk({tag, ".word"}, rand_out, m_words[m_idx]);
    endtask

    task automatic cyc(input string tag, input bit sv, input logic [255:0] sd,
                       input logic [15:0] p, input bit rdy);
        seed_valid   = sv;
        entropy_seed = sd;
        phi_acoustic = mk_phi(p);
        rand_ready   = rdy;
        predict(sv, sd, phi_acoustic, rdy);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".out"}, rand_out, 64'd0);
        chk({tag, ".valid"}, 64'(rand_valid), 64'd0);
        chk({tag, ".reseed"}, 64'(reseed_req), 64'd1);
        chk({tag, ".served"}, 64'(words_served), 64'd0);
        chk({tag, ".rejected"}, 64'(seeds_rejected), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        seed_valid = 0;
        rand_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(tag);
        rst = 0;
        model_reset();
    endtask

    initial begin
        logic [255:0] s4321;
        logic [255:0] sd;
        logic [15:0]  p;
        int           xfers;
        s4321 = {64'd4, 64'd3, 64'd2, 64'd1};
        model_reset();

        do_reset("rst0");

        // Coherence exactly at threshold is rejected
        for (int i = 0; i < 3; i++) cyc("phi_eq", 1, s4321, 16'hD999, 0);
        chk("phi_eq.rej3", 64'(seeds_rejected), 64'd3);
        chk("phi_eq.req", 64'(reseed_req), 64'd1);

        do_reset("rst1");
        cyc("zero_seed", 1, '0, 16'hE000, 0);
        chk("zero_seed.rej1", 64'(seeds_rejected), 64'd1);
        for (int i = 0; i < 3; i++) cyc("zero_seed_idle", 0, '0, 16'hE000, 1);
        chk("zero_seed.valid", 64'(rand_valid), 64'd0);

        do_reset("rst2");
        cyc("known.accept", 1, s4321, 16'hE000, 0);
        chk("known.seeding_req", 64'(reseed_req), 64'd0);
        cyc("known.first", 0, s4321, 16'hE000, 0);
        chk("known.valid", 64'(rand_valid), 64'd1);
        chk("known.word0", rand_out, 64'd11520);
        cyc("known.xfer", 0, s4321, 16'hE000, 1);
        chk("known.word1", rand_out, 64'd0);
        chk("known.served1", 64'(words_served), 64'd1);

        // Stall with seed offers and coherence changes: nothing moves
        for (int i = 0; i < 10; i++)
            cyc("stall", (i % 3) == 0, rnd_seed(), 16'(i * 16'h1111), 0);
        chk("stall.word", rand_out, 64'd0);
        chk("stall.served", 64'(words_served), 64'd1);
        chk("stall.rej", 64'(seeds_rejected), 64'd0);

        for (int i = 0; i < 3; i++) cyc("drain", 0, '0, 16'hE000, 1);
        chk("drain.valid", 64'(rand_valid), 64'd0);
        chk("drain.req", 64'(reseed_req), 64'd1);
        chk("drain.served", 64'(words_served), 64'd4);

        // Reseed from STALE with ready held high: four back-to-back transfers
        cyc("reseed.accept", 1, rnd_seed() | 256'd1, 16'hF000, 1);
        cyc("reseed.warm", 0, '0, 16'hE000, 1);
        xfers = 0;
        for (int i = 0; i < 6; i++) begin
            if (rand_valid) xfers++;
            cyc("burst", 0, '0, 16'h0000, 1);
        end
        chk("burst.xfers", 64'(xfers), 64'd4);
        chk("burst.served", 64'(words_served), 64'd4);
        chk("burst.valid", 64'(rand_valid), 64'd0);

        // Asynchronous reset while a transfer is pending
        cyc("async.accept", 1, rnd_seed() | 256'd2, 16'hE001, 1);
        cyc("async.warm", 0, '0, 16'hE000, 1);
        cyc("async.run", 0, '0, 16'hE000, 1);
        chk("async.pre_valid", 64'(rand_valid), 64'd1);
        #2 rst = 1;
        #1 check_reset_vals("async");
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int i = 0; i < 4; i++) cyc("post_rst", 0, rnd_seed(), 16'hE000, 1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            sd = (($urandom % 10) == 0) ? '0 : rnd_seed();
            case ($urandom % 4)
                0: p = 16'hD999;
                1: p = 16'hD99A;
                2: p = 16'($urandom % 32'hD999);
                default: p = 16'($urandom_range(16'hD99A, 16'hFFFF));
            endcase
            cyc("rand", ($urandom % 3) == 0, sd, p, ($urandom % 4) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arkhe_noise_engine.md
ARKHE_NOISE_ENGINE -- requirements
Module: arkhe_noise_engine

Interface
REQ-001 SHALL have parameter PHI_MIN, default 16'hD999, minimum coherence (phi_in[47:32]) for seed acceptance.
REQ-002 SHALL have parameter RESEED_INTERVAL, default 4096, number of words served per seed (range 1..65535).
REQ-003 SHALL have port clk_100mhz  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port entropy_seed  input  256  seed from the acoustic-coherence stage.
REQ-006 SHALL have port seed_valid  input  1  entropy_seed valid (level, may stay high many cycles).
REQ-007 SHALL have port phi_acoustic  input  64  coherence, Q16.48; only bits [47:32] are compared.
REQ-008 SHALL have port rand_out  output  64  random word.
REQ-009 SHALL have port rand_valid  output  1  rand_out valid.
REQ-010 SHALL have port rand_ready  input  1  consumer accepts word.
REQ-011 SHALL have port reseed_req  output  1  high when a seed is needed (UNSEEDED or STALE).
REQ-012 SHALL have port words_served  output  16  words transferred since last seed load.
REQ-013 SHALL have port seeds_rejected  output  16  count of rejected seed offers, saturating at 16'hFFFF.

Function
REQ-014 SHALL implement FSM UNSEEDED -> SEEDING -> RUN -> STALE -> SEEDING; no other transitions except reset.
REQ-015 SHALL define "seed offer" as seed_valid=1 in UNSEEDED or STALE; offers in SEEDING/RUN are ignored (not counted).
REQ-016 SHALL accept an offer only if phi_acoustic[47:32] > PHI_MIN (strict) and entropy_seed != 0; otherwise increment seeds_rejected (saturating) and stay.
REQ-017 SHALL pack state words s0=seed[63:0], s1=seed[127:64], s2=seed[191:128], s3=seed[255:192].
REQ-018 SHALL, on accept in UNSEEDED, load state = seed; in STALE, load state = state XOR seed, or seed if that XOR is all-zero.
REQ-019 SHALL move to SEEDING the cycle after accept, clear words_served, deassert reseed_req.
REQ-020 SHALL in SEEDING register rand_out = F(state), update state = N(state), set rand_valid=1, go to RUN (first word valid 2 cycles after accept edge).
REQ-021 SHALL use F(s) = rotl64(s1*5, 7)*9, products truncated to 64 bits.
REQ-022 SHALL use N(s): t=s1<<17; s2^=s0; s3^=s1; s1^=s2; s0^=s3; s2^=t; s3=rotl64(s3,45), sequential in that order.
REQ-023 SHALL transfer a word when rand_valid && rand_ready on a rising edge; rand_out SHALL hold stable while rand_valid && !rand_ready.
REQ-024 SHALL on transfer increment words_served; if new value == RESEED_INTERVAL: rand_valid<=0, go STALE; else rand_out<=F(state), state<=N(state) same edge (zero-bubble, one word per cycle).
REQ-025 SHALL keep rand_valid=0 in UNSEEDED, SEEDING-entry, STALE; reseed_req=1 exactly in UNSEEDED and STALE.
REQ-026 SHALL ignore phi_acoustic changes while in SEEDING/RUN.
REQ-027 SHALL never present a word generated from an all-zero state.

Reset
REQ-028 SHALL on rst asynchronously force: state UNSEEDED, s0..s3=0, rand_out=0, rand_valid=0, reseed_req=1, words_served=0, seeds_rejected=0.
REQ-029 SHALL, on reset mid-RUN (including with rand_valid && rand_ready), drop the pending word; no transfer is counted.
REQ-030 SHALL require a new accepted seed after reset before any rand_valid.

Verification
REQ-031 SHALL cover: seed {s3..s0}={4,3,2,1}, phi[47:32]=16'hE000, seed_valid 1 cycle -> 2 cycles later rand_valid=1, rand_out=64'd11520; after one handshake rand_out=0.
REQ-032 SHALL cover: phi[47:32]=16'hD999 (equal) with nonzero seed, 3 cycles seed_valid -> no accept, seeds_rejected=3, reseed_req=1.
REQ-033 SHALL cover: entropy_seed=0, phi 16'hE000 -> rejected, seeds_rejected=1, rand_valid stays 0.
REQ-034 SHALL cover: RESEED_INTERVAL=4, rand_ready held 1 -> exactly 4 transfers on consecutive cycles, then rand_valid=0, reseed_req=1, words_served=4.
REQ-035 SHALL cover: rand_ready low 10 cycles in RUN -> rand_out unchanged, words_served unchanged; seed_valid pulses during RUN ignored.
REQ-036 SHALL cover: rst asserted asynchronously mid-RUN -> outputs at REQ-028 values before next clock edge.
